// File: rtl/cpu_region_mon.sv
// Multi-window CPU access monitor: per-region exec/write/read policy, sticky trap,
// first-violation capture and a saturating violation counter behind a word-mapped API.
module cpu_region_mon #(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned CTR_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  output logic        force_trap,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam int unsigned IDX_W = 3;
  localparam logic [CTR_W-1:0] CNT_MAX = '1;

  logic [31:0]       first_q [NUM_REGIONS];
  logic [31:0]       last_q  [NUM_REGIONS];
  logic [2:0]        mode_q  [NUM_REGIONS];
  logic              enable_q;
  logic              lock_q;
  logic              seen_q;
  logic [1:0]        cause_q;
  logic [IDX_W-1:0]  region_q;
  logic [31:0]       viol_addr_q;
  logic [CTR_W-1:0]  cnt_q;

  logic [1:0]        cls_c;
  logic [2:0]        cls_mask_c;
  logic              viol_c;
  logic [IDX_W-1:0]  viol_idx_c;
  logic              api_wr_c;

  assign ready    = cs;
  assign api_wr_c = cs && we && !lock_q;

  // Access class: 1 exec, 2 write, 3 read; mask lines up with MODE bits.
  always_comb begin
    cls_c      = 2'd3;
    cls_mask_c = 3'b100;
    if (cpu_instr) begin
      cls_c      = 2'd1;
      cls_mask_c = 3'b001;
    end else if (|cpu_wstrb) begin
      cls_c      = 2'd2;
      cls_mask_c = 3'b010;
    end
  end

  // Ascending scan so the lowest violating region is reported.
  always_comb begin
    viol_c     = 1'b0;
    viol_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (cpu_valid && enable_q && !viol_c &&
          (cpu_addr >= first_q[i]) && (cpu_addr <= last_q[i]) &&
          (|(mode_q[i] & cls_mask_c))) begin
        viol_c     = 1'b1;
        viol_idx_c = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
        mode_q[i]  <= '0;
      end
      enable_q    <= 1'b0;
      lock_q      <= 1'b0;
      seen_q      <= 1'b0;
      cause_q     <= '0;
      region_q    <= '0;
      viol_addr_q <= '0;
      cnt_q       <= '0;
      force_trap  <= 1'b0;
    end else begin
      if (api_wr_c) begin
        if (address == 8'h00) begin
          enable_q <= write_data[0];
          lock_q   <= write_data[1];
        end
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
          if (address == 8'(32'h10 + 2 * i)) first_q[i] <= write_data;
          if (address == 8'(32'h11 + 2 * i)) last_q[i]  <= write_data;
          if (address == 8'(32'h30 + i))     mode_q[i]  <= write_data[2:0];
        end
      end
      if (viol_c) begin
        force_trap <= 1'b1;
        if (!seen_q) begin
          seen_q      <= 1'b1;
          cause_q     <= cls_c;
          region_q    <= viol_idx_c;
          viol_addr_q <= cpu_addr;
        end
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CTR_W'(1);
      end
    end
  end

  // Combinational read mux; zero when not a read.
  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      case (address)
        8'h00:   read_data = {30'b0, lock_q, enable_q};
        8'h01:   read_data = {14'b0, enable_q, lock_q, 5'b0, region_q, 4'b0, cause_q, 1'b0, seen_q};
        8'h02:   read_data = viol_addr_q;
        8'h03:   read_data = 32'(cnt_q);
        8'h04:   read_data = 32'(NUM_REGIONS);
        default: read_data = '0;
      endcase
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (address == 8'(32'h10 + 2 * i)) read_data = first_q[i];
        if (address == 8'(32'h11 + 2 * i)) read_data = last_q[i];
        if (address == 8'(32'h30 + i))     read_data = {29'b0, mode_q[i]};
      end
    end
  end

endmodule

// File: tb/tb_cpu_region_mon.sv
// Scoreboard bench for cpu_region_mon: directed scenarios plus random traffic
// checked against a behavioural model of the region rules.
module tb_cpu_region_mon;

  localparam int unsigned NR      = 4;
  localparam int unsigned CW      = 2;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic        clk;
  logic        reset_n;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_addr;
  logic        force_trap;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  cpu_region_mon #(.NUM_REGIONS(NR), .CTR_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_addr   (cpu_addr),
    .force_trap (force_trap),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   mon_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_first [8];
  logic [31:0] m_last  [8];
  logic [2:0]  m_mode  [8];
  bit          m_en, m_lock, m_seen, m_trap;
  logic [1:0]  m_cause;
  logic [2:0]  m_region;
  logic [31:0] m_addr;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_first[r] = '0;
      m_last[r]  = '0;
      m_mode[r]  = '0;
    end
    m_en = 0; m_lock = 0; m_seen = 0; m_trap = 0;
    m_cause = '0; m_region = '0; m_addr = '0; m_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int unsigned ai;
    logic [31:0] v;
    ai = a;
    v  = '0;
    if (ai == 0) begin
      v[0] = m_en; v[1] = m_lock;
    end else if (ai == 1) begin
      v[0] = m_seen; v[3:2] = m_cause; v[10:8] = m_region; v[16] = m_lock; v[17] = m_en;
    end else if (ai == 2) v = m_addr;
    else if (ai == 3) v = m_cnt;
    else if (ai == 4) v = NR;
    else if (ai >= 16 && ai < 16 + 2 * NR) v = ((ai - 16) % 2 == 0) ? m_first[(ai - 16) / 2] : m_last[(ai - 16) / 2];
    else if (ai >= 48 && ai < 48 + NR) v = {29'b0, m_mode[ai - 48]};
    return v;
  endfunction

  // Applies one clock edge worth of behaviour using the inputs held in that cycle.
  task automatic model_step();
    bit          found;
    int unsigned vr, ai;
    logic [2:0]  cm;
    logic [1:0]  cls;
    if (!reset_n) begin
      model_reset();
      return;
    end
    cm  = cpu_instr ? 3'b001 : ((cpu_wstrb != 0) ? 3'b010 : 3'b100);
    cls = cpu_instr ? 2'd1 : ((cpu_wstrb != 0) ? 2'd2 : 2'd3);
    found = 0; vr = 0;
    if (cpu_valid && m_en)
      for (int unsigned r = 0; r < NR; r++)
        if (!found && cpu_addr >= m_first[r] && cpu_addr <= m_last[r] && (m_mode[r] & cm) != 0) begin
          found = 1; vr = r;
        end
    if (found) begin
      m_trap = 1;
      if (!m_seen) begin
        m_seen = 1; m_cause = cls; m_region = 3'(vr); m_addr = cpu_addr;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    ai = address;
    if (cs && we && !m_lock) begin
      if (ai == 0) begin
        m_en = write_data[0]; m_lock = write_data[1];
      end else if (ai >= 16 && ai < 16 + 2 * NR) begin
        if ((ai - 16) % 2 == 0) m_first[(ai - 16) / 2] = write_data;
        else m_last[(ai - 16) / 2] = write_data;
      end else if (ai >= 48 && ai < 48 + NR) m_mode[ai - 48] = write_data[2:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    reset_n = 1; cpu_valid = 0; cpu_instr = 0; cpu_wstrb = 0; cpu_addr = 0;
    cs = 0; we = 0; address = 0; write_data = 0;
  endtask

  task automatic api_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1; we = 1; address = a; write_data = d;
    tick();
  endtask

  task automatic api_read(input logic [7:0] a, input logic [31:0] exp);
    cs = 1; we = 0; address = a;
    q.push_back('{a, exp});
    tick();
  endtask

  task automatic access(input logic instr, input logic [3:0] wstrb, input logic [31:0] addr);
    cpu_valid = 1; cpu_instr = instr; cpu_wstrb = wstrb; cpu_addr = addr;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
  endtask

  // Monitor: pops the scoreboard on every API read, checks trap and ready every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", 32'(ready), 32'(cs));
      chk("force_trap", 32'(force_trap), 32'(m_trap));
      if (cs && !we) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL scoreboard: read at 0x%02h with no expected entry", address);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("rd[0x%02h]", e.a), read_data, e.d);
        end
      end else begin
        chk("rdata_idle", read_data, 32'h0);
      end
    end
  end

  initial begin
    reset_n = 0; cpu_valid = 0; cpu_instr = 0; cpu_wstrb = 0; cpu_addr = 0;
    cs = 0; we = 0; address = 0; write_data = 0;
    model_reset();
    do_reset();
    do_reset();
    mon_en = 1;

    // Reset values
    api_read(8'h00, 32'h0);
    api_read(8'h01, 32'h0);
    api_read(8'h02, 32'h0);
    api_read(8'h03, 32'h0);
    api_read(8'h04, 32'd4);
    api_read(8'h10, 32'h0);

    // Lock and exec trap
    api_write(8'h10, 32'h4000_0000);
    api_write(8'h11, 32'h4000_00FF);
    api_write(8'h30, 32'h1);
    api_write(8'h00, 32'h3);
    access(1'b0, 4'h0, 32'h4000_0010);
    api_read(8'h03, 32'h0);
    api_write(8'h30, 32'h0);
    api_read(8'h30, 32'h1);
    api_write(8'h00, 32'h0);
    api_read(8'h00, 32'h3);
    api_read(8'h01, 32'h0003_0000);
    access(1'b1, 4'h0, 32'h4000_0010);
    api_read(8'h01, 32'h0003_0005);
    api_read(8'h02, 32'h4000_0010);
    api_read(8'h03, 32'h1);

    // Reset mid-trap clears trap and lock
    do_reset();
    api_read(8'h00, 32'h0);
    api_read(8'h01, 32'h0);
    api_write(8'h12, 32'h1234_5678);
    api_read(8'h12, 32'h1234_5678);

    // Overlap priority, first capture, saturation
    api_write(8'h12, 32'h4000_1000);
    api_write(8'h13, 32'h4000_1FFF);
    api_write(8'h14, 32'h4000_1000);
    api_write(8'h15, 32'h4000_1FFF);
    api_write(8'h31, 32'h2);
    api_write(8'h32, 32'h2);
    api_write(8'h00, 32'h1);
    access(1'b0, 4'hF, 32'h4000_1000);
    api_read(8'h01, 32'h0002_0109);
    access(1'b0, 4'h1, 32'h4000_1004);
    api_read(8'h02, 32'h4000_1000);
    api_read(8'h03, 32'h2);
    repeat (3) access(1'b0, 4'h2, 32'h4000_1008);
    api_read(8'h03, 32'h3);

    // Boundaries, inverted region, disable, unmapped
    do_reset();
    api_write(8'h10, 32'h0000_1000);
    api_write(8'h11, 32'h0000_1FFF);
    api_write(8'h30, 32'h7);
    api_write(8'h16, 32'h0000_3000);
    api_write(8'h17, 32'h0000_2000);
    api_write(8'h33, 32'h7);
    api_write(8'h00, 32'h1);
    access(1'b0, 4'h0, 32'h0000_0FFF);
    api_read(8'h03, 32'h0);
    access(1'b0, 4'h0, 32'h0000_1000);
    api_read(8'h03, 32'h1);
    access(1'b1, 4'h0, 32'h0000_1FFF);
    api_read(8'h03, 32'h2);
    access(1'b0, 4'h0, 32'h0000_2000);
    access(1'b0, 4'h0, 32'h0000_2800);
    access(1'b0, 4'h4, 32'h0000_3000);
    api_read(8'h03, 32'h2);
    api_read(8'h01, 32'h0002_000D);
    api_write(8'h00, 32'h0);
    access(1'b0, 4'h0, 32'h0000_1000);
    api_read(8'h03, 32'h2);
    api_write(8'h18, 32'h0000_FFFF);
    api_read(8'h18, 32'h0);
    api_read(8'h35, 32'h0);
    api_read(8'h05, 32'h0);
    api_read(8'h20, 32'h0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int unsigned op, sel;
      if ($urandom_range(0, 299) == 0) reset_n = 0;
      if ($urandom_range(0, 1) == 1) begin
        cpu_valid = 1;
        cpu_instr = ($urandom_range(0, 2) == 0);
        cpu_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        cpu_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      end
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: address = 8'(sel);
        5, 6:          address = 8'(16 + $urandom_range(0, 9));
        7:             address = 8'(48 + $urandom_range(0, 5));
        default:       address = 8'($urandom_range(0, 255));
      endcase
      op = $urandom_range(0, 3);
      if (op == 2) begin
        cs = 1; we = 0;
        q.push_back('{address, model_read(address)});
      end else if (op == 3) begin
        cs = 1; we = 1;
        if (address == 8'h00)
          write_data = {30'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0)};
        else
          write_data = 32'($urandom_range(0, 255));
      end
      tick();
    end

    @(negedge clk);
    #1;
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cpu_region_mon.md
# cpu_region_mon

Parametrised CPU access monitor for the tk1 SoC. It replaces the single execute-only address window with NUM_REGIONS independent windows. Each window carries its own no-exec, no-write and no-read policy bits, and the whole configuration can be locked until reset. On a violation it asserts a sticky force_trap and records the first offending address, access type and region. It also keeps a saturating violation counter. It sits beside the tk1 core on the CPU bus snoop path and on the memory-mapped API bus.

## Interface
Parameters:
- NUM_REGIONS, 4, number of monitored windows; legal range 1..8.
- CTR_W, 8, width of the saturating violation counter; legal range 1..32.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- cpu_valid  in  1  CPU bus access valid this cycle.
- cpu_instr  in  1  access is an instruction fetch.
- cpu_wstrb  in  4  byte write strobes; nonzero means a data write.
- cpu_addr  in  32  access address.
- force_trap  out  1  sticky trap request to the CPU.
- cs  in  1  API chip select.
- we  in  1  API write enable.
- address  in  8  API word address.
- write_data  in  32  API write data.
- read_data  out  32  API read data; combinational.
- ready  out  1  API ready; equals cs in the same cycle.

## Operation
- Access classification, evaluated only when cpu_valid=1:
  - exec: cpu_instr=1.
  - write: cpu_instr=0 and cpu_wstrb!=0.
  - read: all other accesses.
- Region i hits when enable=1 and first_i <= cpu_addr <= last_i (unsigned compare).
  - If first_i > last_i the region never hits.
- Region i violates on a hit when its policy blocks the access class:
  - MODE bit0 blocks exec.
  - MODE bit1 blocks write.
  - MODE bit2 blocks read.
- Violation in any region: force_trap is set and stays set until reset.
- First violation since reset captures:
  - VIOL_ADDR = cpu_addr.
  - cause = access class (1 exec, 2 write, 3 read).
  - region = lowest violating region index.
  - Later violations do not overwrite these fields.
- VIOL_CNT increments by 1 on every violating cycle and saturates at 2^CTR_W-1.
- API register map (word addresses):
  - 0x00 CTRL: bit0 enable, bit1 lock. Write sets both bits from write_data. Once lock=1, CTRL writes are ignored; lock clears only on reset.
  - 0x01 STATUS (RO): bit0 violation seen, bits[3:2] cause, bits[10:8] region, bit16 lock, bit17 enable.
  - 0x02 VIOL_ADDR (RO).
  - 0x03 VIOL_CNT (RO), zero-extended to 32 bits.
  - 0x04 NUM_REGIONS (RO) constant.
  - 0x10+2i FIRST_i and 0x11+2i LAST_i (RW, 32 bits).
  - 0x30+i MODE_i (RW, bits[2:0]).
- Writes to FIRST, LAST and MODE are ignored while lock=1. Reads are always allowed.
- Addresses that are unmapped, or belong to regions i>=NUM_REGIONS, read 0 and ignore writes.
- read_data is 0 when cs=0 or we=1.

## Timing
- Reset values: force_trap=0, all config and status registers 0, VIOL_CNT=0.
- read_data and ready are combinational; ready=cs.
- Violation latency: a violating access in cycle N gives force_trap=1 and updated STATUS/VIOL_ADDR/VIOL_CNT from cycle N+1.
- An API write in cycle N takes effect at N+1. An access in cycle N is checked against the configuration registered before N, not the value being written in N.
- A lock write and a config write cannot occur in the same cycle (single API port). The lock state at N governs writes at N.
- Overlapping regions: any violating region traps; the reported region is the lowest index.
- Reset asserted mid-operation clears everything, including a sticky trap and the lock, on the next clk edge.

## Test plan
- Lock: reset; FIRST_0=0x40000000, LAST_0=0x400000FF, MODE_0=1, CTRL=0x3; then write MODE_0=0 -> MODE_0 still reads 1, STATUS bit16=1.
- Exec trap: fetch at 0x40000010 -> force_trap=1 one cycle later, STATUS=0x00030005, VIOL_ADDR=0x40000010. A data read at the same address beforehand -> no trap.
- Priority and first-capture: regions 1 and 2 both cover 0x40001000 with MODE=2; write there -> region=1, cause=2. A subsequent write to 0x40001004 -> VIOL_ADDR unchanged, VIOL_CNT=2.
- Saturation: CTR_W=2, five violating cycles -> VIOL_CNT=3.
- Boundaries: access at first_i and at last_i -> trap; at last_i+1 -> none. A region with first>last never traps. With enable=0 there is no trap.
- Reset mid-trap: after force_trap=1, pulse reset_n=0 for 1 cycle -> force_trap=0, CTRL=0, and config is writable again.
